// File: rtl/mc_stage_sequencer_if.sv
// Control/status bundle for mc_stage_sequencer: run/step/memory handshake
// inputs and the stage, strobe, fault and retire-count outputs.
interface mc_stage_sequencer_if #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3,
    parameter int CNT_W      = 16
);
    logic                  Run;
    logic                  Step_Mode;
    logic                  Step_Pulse;
    logic                  Mem_Access;
    logic                  MEM_MFC;
    logic                  MEM_ERROR;
    logic                  Clear_Fault;
    logic [STAGE_W-1:0]    Stage;
    logic [NUM_STAGES-1:0] Stage_OneHot;
    logic                  Mem_Request;
    logic                  Stage_Advance;
    logic                  Instr_Done;
    logic                  Fault;
    logic [1:0]            Fault_Code;
    logic [CNT_W-1:0]      Instr_Count;

    modport master (
        output Run, Step_Mode, Step_Pulse, Mem_Access, MEM_MFC, MEM_ERROR, Clear_Fault,
        input  Stage, Stage_OneHot, Mem_Request, Stage_Advance, Instr_Done,
               Fault, Fault_Code, Instr_Count
    );

    modport slave (
        input  Run, Step_Mode, Step_Pulse, Mem_Access, MEM_MFC, MEM_ERROR, Clear_Fault,
        output Stage, Stage_OneHot, Mem_Request, Stage_Advance, Instr_Done,
               Fault, Fault_Code, Instr_Count
    );
endinterface

// File: rtl/mc_stage_sequencer.sv
// Parametrised multicycle stage sequencer: memory-stage stalls on MFC, sticky
// fault on memory error or timeout, single-step debug and retired-instruction count.
module mc_stage_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int STAGE_W        = 3,
    parameter int FETCH_STAGE    = 1,
    parameter int MEM_STAGE      = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    mc_stage_sequencer_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [STAGE_W-1:0]    FIRST_S   = STAGE_W'(1);
    localparam logic [STAGE_W-1:0]    LAST_S    = STAGE_W'(NUM_STAGES);
    localparam logic [STAGE_W-1:0]    FETCH_S   = STAGE_W'(FETCH_STAGE);
    localparam logic [STAGE_W-1:0]    MEMST_S   = STAGE_W'(MEM_STAGE);
    localparam logic [WAIT_W-1:0]     LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0] OH_FIRST  = NUM_STAGES'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                state_r, state_n;
    logic [STAGE_W-1:0]    stage_r, stage_n;
    logic [NUM_STAGES-1:0] onehot_r, onehot_n;
    logic [1:0]            fault_code_r, fault_code_n;
    logic [CNT_W-1:0]      count_r, count_n;
    logic [WAIT_W-1:0]     wait_cnt_r, wait_cnt_n;
    logic                  mfc_seen_r, mfc_seen_n;

    logic running_s;
    logic mem_stage_s;
    logic mem_req_s;
    logic err_s;
    logic timeout_s;
    logic ready_s;
    logic adv_s;
    logic done_s;

    // Strobe decode; a memory error suppresses the advance even when MFC is present.
    always_comb begin
        running_s   = (state_r == ST_RUN) && bus.Run;
        mem_stage_s = (stage_r == FETCH_S) || ((stage_r == MEMST_S) && bus.Mem_Access);
        mem_req_s   = running_s && mem_stage_s;
        err_s       = mem_req_s && bus.MEM_ERROR;
        timeout_s   = mem_req_s && !bus.MEM_MFC && !mfc_seen_r && (wait_cnt_r == LAST_WAIT);
        ready_s     = !mem_stage_s || mfc_seen_r || (mem_req_s && bus.MEM_MFC);
        adv_s       = running_s && ready_s && (!bus.Step_Mode || bus.Step_Pulse) && !err_s;
        done_s      = adv_s && (stage_r == LAST_S);
    end

    // Next-state and datapath update for the RUN/FAULT machine.
    always_comb begin
        state_n      = state_r;
        stage_n      = stage_r;
        onehot_n     = onehot_r;
        fault_code_n = fault_code_r;
        count_n      = count_r;
        wait_cnt_n   = wait_cnt_r;
        mfc_seen_n   = mfc_seen_r;
        case (state_r)
            ST_RUN: begin
                if (err_s) begin
                    state_n      = ST_FAULT;
                    fault_code_n = 2'b01;
                end else if (timeout_s) begin
                    state_n      = ST_FAULT;
                    fault_code_n = 2'b10;
                end else if (adv_s) begin
                    stage_n    = (stage_r == LAST_S) ? FIRST_S : stage_r + STAGE_W'(1);
                    onehot_n   = {onehot_r[NUM_STAGES-2:0], onehot_r[NUM_STAGES-1]};
                    wait_cnt_n = {WAIT_W{1'b0}};
                    mfc_seen_n = 1'b0;
                    if (done_s) begin
                        count_n = count_r + CNT_W'(1);
                    end else begin
                        count_n = count_r;
                    end
                end else begin
                    // Latch a short MFC pulse so the stage can still complete later.
                    if (mem_req_s && bus.MEM_MFC) begin
                        mfc_seen_n = 1'b1;
                    end else begin
                        mfc_seen_n = mfc_seen_r;
                    end
                    if (mem_req_s && !bus.MEM_MFC && !mfc_seen_r) begin
                        wait_cnt_n = wait_cnt_r + WAIT_W'(1);
                    end else begin
                        wait_cnt_n = wait_cnt_r;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.Clear_Fault) begin
                    state_n      = ST_RUN;
                    stage_n      = FIRST_S;
                    onehot_n     = OH_FIRST;
                    fault_code_n = 2'b00;
                    wait_cnt_n   = {WAIT_W{1'b0}};
                    mfc_seen_n   = 1'b0;
                end else begin
                    state_n = ST_FAULT;
                end
            end
            default: begin
                state_n      = ST_RUN;
                stage_n      = FIRST_S;
                onehot_n     = OH_FIRST;
                fault_code_n = 2'b00;
                wait_cnt_n   = {WAIT_W{1'b0}};
                mfc_seen_n   = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= ST_RUN;
            stage_r      <= FIRST_S;
            onehot_r     <= OH_FIRST;
            fault_code_r <= 2'b00;
            count_r      <= {CNT_W{1'b0}};
            wait_cnt_r   <= {WAIT_W{1'b0}};
            mfc_seen_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            stage_r      <= stage_n;
            onehot_r     <= onehot_n;
            fault_code_r <= fault_code_n;
            count_r      <= count_n;
            wait_cnt_r   <= wait_cnt_n;
            mfc_seen_r   <= mfc_seen_n;
        end
    end

    // Mem_Request and Stage_Advance stay combinational so datapath enables capture on the same edge.
    assign bus.Stage         = stage_r;
    assign bus.Stage_OneHot  = onehot_r;
    assign bus.Mem_Request   = mem_req_s;
    assign bus.Stage_Advance = adv_s;
    assign bus.Instr_Done    = done_s;
    assign bus.Fault         = (state_r == ST_FAULT);
    assign bus.Fault_Code    = fault_code_r;
    assign bus.Instr_Count   = count_r;
endmodule

// File: tb/tb_mc_stage_sequencer.sv
// Directed bench for mc_stage_sequencer: default 5-stage instance plus a
// 3-stage / 4-bit-counter instance for wrap and one-hot rotation.
module tb_mc_stage_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mc_stage_sequencer_if #(.NUM_STAGES(5), .STAGE_W(3), .CNT_W(16)) bus ();
    mc_stage_sequencer_if #(.NUM_STAGES(3), .STAGE_W(2), .CNT_W(4))  bus2 ();

    mc_stage_sequencer #(
        .NUM_STAGES(5), .STAGE_W(3), .FETCH_STAGE(1), .MEM_STAGE(4),
        .TIMEOUT_CYCLES(16), .CNT_W(16)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    mc_stage_sequencer #(
        .NUM_STAGES(3), .STAGE_W(2), .FETCH_STAGE(1), .MEM_STAGE(2),
        .TIMEOUT_CYCLES(16), .CNT_W(4)
    ) dut2 (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the main instance: drive MFC/ERROR, check stage and strobes, then clock.
    task automatic cyc(input string tag, input logic mfc, input logic err, input int es,
                       input logic ea, input logic em, input logic ed);
        bus.MEM_MFC   = mfc;
        bus.MEM_ERROR = err;
        #2;
        chk({tag, "_stage"}, 32'(bus.Stage), 32'(es));
        chk({tag, "_adv"},   32'(bus.Stage_Advance), 32'(ea));
        chk({tag, "_mreq"},  32'(bus.Mem_Request), 32'(em));
        chk({tag, "_done"},  32'(bus.Instr_Done), 32'(ed));
        tick();
    endtask

    initial begin
        int k;
        int es;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.Run = 1'b0;  bus.Step_Mode = 1'b0; bus.Step_Pulse = 1'b0; bus.Mem_Access = 1'b0;
        bus.MEM_MFC = 1'b0; bus.MEM_ERROR = 1'b0; bus.Clear_Fault = 1'b0;
        bus2.Run = 1'b0; bus2.Step_Mode = 1'b0; bus2.Step_Pulse = 1'b0; bus2.Mem_Access = 1'b0;
        bus2.MEM_MFC = 1'b0; bus2.MEM_ERROR = 1'b0; bus2.Clear_Fault = 1'b0;
        tick();

        chk("rst_stage",  32'(bus.Stage), 32'd1);
        chk("rst_onehot", 32'(bus.Stage_OneHot), 32'h01);
        chk("rst_fault",  32'(bus.Fault), 32'd0);
        chk("rst_code",   32'(bus.Fault_Code), 32'd0);
        chk("rst_count",  32'(bus.Instr_Count), 32'd0);
        chk("rst_adv",    32'(bus.Stage_Advance), 32'd0);
        chk("rst_done",   32'(bus.Instr_Done), 32'd0);
        chk("rst2_onehot", 32'(bus2.Stage_OneHot), 32'h1);
        rst_n   = 1'b1;
        bus.Run = 1'b1;

        // MFC two cycles after fetch entry, no data memory: 7 cycles per instruction.
        for (int c = 0; c < 21; c++) begin
            k  = c % 7;
            es = (k < 3) ? 1 : k - 1;
            cyc("t1", k == 2, 1'b0, es, k >= 2, k < 3, k == 6);
        end
        chk("t1_count", 32'(bus.Instr_Count), 32'd3);

        // Data memory stage with a 1-cycle MFC on its third cycle.
        bus.Mem_Access = 1'b1;
        cyc("t2", 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        cyc("t2", 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        cyc("t2", 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        cyc("t2", 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        cyc("t2", 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        cyc("t2", 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0);
        cyc("t2", 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1);
        chk("t2_count", 32'(bus.Instr_Count), 32'd4);

        // Single-step: held pulse, MFC retained across cycles, pulse under Run=0 dropped.
        bus.Step_Mode  = 1'b1;
        bus.Step_Pulse = 1'b1;
        cyc("t5", 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        cyc("t5", 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        cyc("t5", 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        bus.Step_Pulse = 1'b0;
        cyc("t5", 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        cyc("t5", 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        bus.Step_Pulse = 1'b1;
        cyc("t5", 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0);
        bus.Step_Pulse = 1'b0;
        cyc("t5", 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0);
        bus.Step_Pulse = 1'b1;
        cyc("t5", 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1);
        chk("t5_count", 32'(bus.Instr_Count), 32'd5);
        bus.Run = 1'b0;
        cyc("t5_run0", 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        bus.Run        = 1'b1;
        bus.Step_Pulse = 1'b0;
        cyc("t5_drop", 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        bus.Step_Pulse = 1'b1;
        cyc("t5", 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);

        // Back to free-running; an error without a memory request is ignored.
        bus.Step_Mode  = 1'b0;
        bus.Step_Pulse = 1'b0;
        bus.Mem_Access = 1'b0;
        cyc("t3_ign", 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        cyc("t3", 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        cyc("t3", 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        cyc("t3", 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1);
        chk("t3_count", 32'(bus.Instr_Count), 32'd6);
        chk("t3_nofault", 32'(bus.Fault), 32'd0);

        // Fetch never completes: timeout fault 16 cycles after stage entry.
        for (int c = 0; c < 16; c++) begin
            cyc("t3_wait", 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        end
        chk("t3_fault", 32'(bus.Fault), 32'd1);
        chk("t3_code",  32'(bus.Fault_Code), 32'd2);
        cyc("t3_hold", 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        bus.Clear_Fault = 1'b1;
        cyc("t3_clr", 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        bus.Clear_Fault = 1'b0;
        chk("t3_clr_fault", 32'(bus.Fault), 32'd0);
        chk("t3_clr_code",  32'(bus.Fault_Code), 32'd0);
        chk("t3_clr_count", 32'(bus.Instr_Count), 32'd6);

        // Error together with MFC in the data stage: error fault, no advance.
        bus.Mem_Access = 1'b1;
        cyc("t4", 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        cyc("t4", 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        cyc("t4", 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        cyc("t4", 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0);
        chk("t4_fault",  32'(bus.Fault), 32'd1);
        chk("t4_code",   32'(bus.Fault_Code), 32'd1);
        chk("t4_onehot", 32'(bus.Stage_OneHot), 32'h08);
        cyc("t4_hold", 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_stage",  32'(bus.Stage), 32'd1);
        chk("t4_rst_onehot", 32'(bus.Stage_OneHot), 32'h01);
        chk("t4_rst_fault",  32'(bus.Fault), 32'd0);
        chk("t4_rst_code",   32'(bus.Fault_Code), 32'd0);
        chk("t4_rst_count",  32'(bus.Instr_Count), 32'd0);
        #1;
        rst_n       = 1'b1;
        bus.Run     = 1'b0;
        bus.MEM_MFC = 1'b0;

        // 3-stage instance, MFC tied high: 17 instructions wrap the 4-bit counter.
        bus2.Run     = 1'b1;
        bus2.MEM_MFC = 1'b1;
        chk("t6_oh0", 32'(bus2.Stage_OneHot), 32'h1);
        tick();
        chk("t6_oh1", 32'(bus2.Stage_OneHot), 32'h2);
        tick();
        chk("t6_oh2", 32'(bus2.Stage_OneHot), 32'h4);
        tick();
        chk("t6_oh3",  32'(bus2.Stage_OneHot), 32'h1);
        chk("t6_cnt1", 32'(bus2.Instr_Count), 32'd1);
        repeat (42) tick();
        chk("t6_cnt15", 32'(bus2.Instr_Count), 32'd15);
        repeat (3) tick();
        chk("t6_cnt0", 32'(bus2.Instr_Count), 32'd0);
        repeat (3) tick();
        chk("t6_cnt1b", 32'(bus2.Instr_Count), 32'd1);
        chk("t6_stage", 32'(bus2.Stage), 32'd1);
        bus2.Run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
